// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between a set of requesters and the round-robin arbiter.
//   enable     permits new grants
//   req[N]     request vector, bit i = requester i
//   done       current grantee finished (single-cycle pulse)
//   gnt[N]     one-hot or all-zero grant
//   gnt_valid  equals |gnt
//   timeout    single-cycle pulse when the watchdog revokes a grant
// master: requester side, slave: arbiter side.
interface rr_arbiter_if #(
    parameter int N = 64
);
    logic         enable;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic         timeout;

    modport master (
        output enable, req, done,
        input  gnt, gnt_valid, timeout
    );

    modport slave (
        input  enable, req, done,
        output gnt, gnt_valid, timeout
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with hold-until-done grants and a watchdog.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   rr_arbiter_if.slave: enable/req/done in, gnt/gnt_valid/timeout out
// A grant is held until done, or revoked after MAX_HOLD cycles without done.
// On done, the next requester (other than the finishing one) is granted in
// the same edge so back-to-back grants carry no idle bubble.
//
// state | meaning
// IDLE  | no grant outstanding; searching when enabled
// GRANT | grant held for requester gnt_idx
module rr_arbiter #(
    parameter int N        = 64,
    parameter int MAX_HOLD = 256
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter_if.slave   bus
);
    localparam int PW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_n;
    logic [PW-1:0] ptr, ptr_n;
    logic [PW-1:0] gnt_idx, gnt_idx_n;
    logic [HW-1:0] hold_cnt, hold_cnt_n;
    logic [N-1:0]  gnt, gnt_n;
    logic          gnt_valid, gnt_valid_n;
    logic          timeout, timeout_n;

    logic [PW-1:0] ptr_inc;
    logic [N-1:0]  cur_mask;
    logic [PW:0]   pick_idle;
    logic [PW:0]   pick_next;

    // First set bit of r in search order p, p+1, ..., N-1, 0, ..., p-1.
    // Result is {found, index}. Walking backwards lets the earliest position
    // in search order overwrite later ones.
    function automatic logic [PW:0] rr_pick(input logic [N-1:0] r,
                                            input logic [PW-1:0] p);
        logic [PW:0] res;
        int          j;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(p) + i;
            if (j >= N) j = j - N;
            if (r[PW'(j)]) res = {1'b1, PW'(j)};
        end
        return res;
    endfunction

    // Wrap at N rather than 2**PW so non-power-of-2 sizes work.
    assign ptr_inc   = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
    assign cur_mask  = N'(1) << gnt_idx;
    assign pick_idle = rr_pick(bus.req, ptr);
    assign pick_next = rr_pick(bus.req & ~cur_mask, ptr_inc);

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        gnt_idx_n   = gnt_idx;
        hold_cnt_n  = hold_cnt;
        gnt_n       = gnt;
        timeout_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.enable && pick_idle[PW]) begin
                    gnt_idx_n  = pick_idle[PW-1:0];
                    gnt_n      = N'(1) << pick_idle[PW-1:0];
                    hold_cnt_n = '0;
                    state_n    = GRANT;
                end
            end
            GRANT: begin
                if (bus.done) begin
                    ptr_n      = ptr_inc;
                    hold_cnt_n = '0;
                    if (bus.enable && pick_next[PW]) begin
                        gnt_idx_n = pick_next[PW-1:0];
                        gnt_n     = N'(1) << pick_next[PW-1:0];
                    end else begin
                        gnt_n   = '0;
                        state_n = IDLE;
                    end
                end else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
                    // done wins over expiry in the same cycle, so only here
                    // does the watchdog fire.
                    ptr_n      = ptr_inc;
                    hold_cnt_n = '0;
                    gnt_n      = '0;
                    timeout_n  = 1'b1;
                    state_n    = IDLE;
                end else begin
                    hold_cnt_n = hold_cnt + HW'(1);
                end
            end
            default: begin
                gnt_n   = '0;
                state_n = IDLE;
            end
        endcase
        gnt_valid_n = |gnt_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_idx   <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            gnt_idx   <= gnt_idx_n;
            hold_cnt  <= hold_cnt_n;
            gnt       <= gnt_n;
            gnt_valid <= gnt_valid_n;
            timeout   <= timeout_n;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.gnt_valid = gnt_valid;
    assign bus.timeout   = timeout;
endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: one N=64 and one N=5 instance, exercised in turn.
// A reference model tracks the selected instance every cycle; directed
// sequences and a vector table cover the listed corner cases.
module tb_rr_arbiter;
    localparam int MH = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_drv = 1'b1;
    int          sel = 0;
    logic        en_drv = 1'b0;
    logic        done_drv = 1'b0;
    logic [63:0] req_drv = '0;
    logic        rst64, rst5;

    assign rst64 = rst_drv | (sel != 0);
    assign rst5  = rst_drv | (sel != 1);

    rr_arbiter_if #(.N(64)) bus64();
    rr_arbiter_if #(.N(5))  bus5();

    assign bus64.enable = en_drv;
    assign bus64.req    = req_drv;
    assign bus64.done   = done_drv;
    assign bus5.enable  = en_drv;
    assign bus5.req     = req_drv[4:0];
    assign bus5.done    = done_drv;

    rr_arbiter #(.N(64), .MAX_HOLD(MH)) dut64 (.clk(clk), .rst(rst64), .bus(bus64));
    rr_arbiter #(.N(5),  .MAX_HOLD(MH)) dut5  (.clk(clk), .rst(rst5),  .bus(bus5));

    int          checks = 0;
    int          errors = 0;
    int          n = 64;
    logic [63:0] mask = '1;

    // reference model state
    int          m_gnt = -1;
    int          m_ptr = 0;
    int          m_age = 0;
    logic        m_to  = 1'b0;
    logic        prev_to64 = 1'b0;
    logic        prev_to5  = 1'b0;

    typedef struct {
        logic        en;
        logic [63:0] req;
        logic        done;
        logic [63:0] exp;
    } vec_t;
    vec_t t2[7];

    function automatic logic [63:0] bit64(input int i);
        logic [63:0] one;
        one = 64'd1;
        return one << i;
    endfunction

    function automatic int pick(input logic [63:0] r, input int p, input int sz);
        for (int i = 0; i < sz; i++) begin
            if (r[(p + i) % sz]) return (p + i) % sz;
        end
        return -1;
    endfunction

    function automatic logic [63:0] cur_gnt();
        return (sel == 0) ? bus64.gnt : {59'b0, bus5.gnt};
    endfunction

    function automatic logic cur_valid();
        return (sel == 0) ? bus64.gnt_valid : bus5.gnt_valid;
    endfunction

    function automatic logic cur_to();
        return (sel == 0) ? bus64.timeout : bus5.timeout;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (n=%0d t=%0t): got %h expected %h", name, n, $time, act, exp);
        end
    endtask

    task automatic model_step();
        logic [63:0] r;
        int          k;
        r = req_drv & mask;
        if (rst_drv) begin
            m_gnt = -1; m_ptr = 0; m_age = 0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_gnt < 0) begin
                k = en_drv ? pick(r, m_ptr, n) : -1;
                if (k >= 0) begin
                    m_gnt = k;
                    m_age = 0;
                end
            end else if (done_drv) begin
                m_ptr = (m_gnt + 1) % n;
                r     = r & ~bit64(m_gnt);
                m_gnt = en_drv ? pick(r, m_ptr, n) : -1;
                m_age = 0;
            end else if (m_age + 1 >= MH) begin
                m_to  = 1'b1;
                m_ptr = (m_gnt + 1) % n;
                m_gnt = -1;
            end else begin
                m_age++;
            end
        end
    endtask

    // One clock: sample #1 after the edge, advance the model, compare.
    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
        check("model_gnt", cur_gnt(), (m_gnt < 0) ? 64'd0 : bit64(m_gnt));
        check("model_gnt_valid", 64'(cur_valid()), 64'(m_gnt >= 0));
        check("model_timeout", 64'(cur_to()), 64'(m_to));
        check("inv_onehot0_64", 64'($onehot0(bus64.gnt)), 64'd1);
        check("inv_onehot0_5", 64'($onehot0(bus5.gnt)), 64'd1);
        check("inv_valid_64", 64'(bus64.gnt_valid), 64'(|bus64.gnt));
        check("inv_valid_5", 64'(bus5.gnt_valid), 64'(|bus5.gnt));
        check("inv_timeout_pair_64", 64'(prev_to64 & bus64.timeout), 64'd0);
        check("inv_timeout_pair_5", 64'(prev_to5 & bus5.timeout), 64'd0);
        prev_to64 = bus64.timeout;
        prev_to5  = bus5.timeout;
    endtask

    task automatic do_reset();
        rst_drv  = 1'b1;
        en_drv   = 1'b0;
        done_drv = 1'b0;
        req_drv  = '0;
        cyc();
        cyc();
        check("reset_gnt", cur_gnt(), 64'd0);
        check("reset_gnt_valid", 64'(cur_valid()), 64'd0);
        check("reset_timeout", 64'(cur_to()), 64'd0);
        rst_drv = 1'b0;
    endtask

    task automatic run_suite(input int s);
        int a, b, c, d;
        rst_drv = 1'b1;
        sel  = s;
        n    = (s == 0) ? 64 : 5;
        mask = (s == 0) ? '1 : 64'h1F;
        a = (s == 0) ? 9 : 3;
        b = (s == 0) ? 5 : 1;
        c = (s == 0) ? 6 : 2;
        d = (s == 0) ? 7 : 4;

        // 1: full rotation with done in every grant's first cycle
        do_reset();
        req_drv = mask;
        en_drv  = 1'b1;
        cyc();
        check("t1_first", cur_gnt(), bit64(0));
        for (int i = 1; i <= n; i++) begin
            done_drv = 1'b1;
            cyc();
            check("t1_rotation", cur_gnt(), bit64(i % n));
        end
        done_drv = 1'b0;

        // 2: enable gating, table driven
        do_reset();
        for (int i = 0; i < 7; i++) begin
            en_drv   = t2[i].en;
            req_drv  = t2[i].req;
            done_drv = t2[i].done;
            cyc();
            check("t2_vec", cur_gnt(), t2[i].exp);
        end
        done_drv = 1'b0;

        // 3: wrap-around search after serving index a
        do_reset();
        en_drv  = 1'b1;
        req_drv = bit64(a);
        cyc();
        check("t3_grant_a", cur_gnt(), bit64(a));
        done_drv = 1'b1;
        req_drv  = bit64(b);
        cyc();
        check("t3_wrap_b", cur_gnt(), bit64(b));
        req_drv = '0;
        cyc();
        check("t3_release", cur_gnt(), 64'd0);
        done_drv = 1'b0;

        // 4: watchdog
        do_reset();
        en_drv  = 1'b1;
        req_drv = bit64(3);
        for (int i = 0; i < MH; i++) begin
            cyc();
            check("t4_held", cur_gnt(), bit64(3));
            check("t4_no_timeout", 64'(cur_to()), 64'd0);
        end
        cyc();
        check("t4_revoked", cur_gnt(), 64'd0);
        check("t4_timeout", 64'(cur_to()), 64'd1);
        req_drv = mask;
        cyc();
        check("t4_next", cur_gnt(), bit64(4));
        check("t4_timeout_clear", 64'(cur_to()), 64'd0);

        // 5: reset mid-grant
        do_reset();
        en_drv  = 1'b1;
        req_drv = bit64(c);
        cyc();
        check("t5_grant", cur_gnt(), bit64(c));
        rst_drv = 1'b1;
        cyc();
        check("t5_rst_gnt", cur_gnt(), 64'd0);
        check("t5_rst_valid", 64'(cur_valid()), 64'd0);
        rst_drv = 1'b0;
        req_drv = mask;
        cyc();
        check("t5_after_rst", cur_gnt(), bit64(0));

        // 6: fairness with a requester holding req through its done
        do_reset();
        en_drv  = 1'b1;
        req_drv = bit64(2) | bit64(d);
        cyc();
        check("t6_first", cur_gnt(), bit64(2));
        done_drv = 1'b1;
        cyc();
        check("t6_other", cur_gnt(), bit64(d));
        cyc();
        check("t6_back", cur_gnt(), bit64(2));
        req_drv = '0;
        cyc();
        check("t6_release", cur_gnt(), 64'd0);
        done_drv = 1'b0;

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            req_drv  = ({$urandom, $urandom} & {$urandom, $urandom}) & mask;
            if ($urandom_range(0, 7) == 0) req_drv = '0;
            en_drv   = ($urandom_range(0, 3) != 0);
            done_drv = ($urandom_range(0, 4) == 0);
            cyc();
        end
        done_drv = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 5; i++) t2[i] = '{1'b0, 64'h10, 1'b0, 64'h0};
        t2[5] = '{1'b1, 64'h10, 1'b0, 64'h10};
        t2[6] = '{1'b1, 64'h0,  1'b1, 64'h0};

        run_suite(0);
        run_suite(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
